// File: rtl/score_digit_driver.sv
// score_digit_driver: saturating score counter, sequential double-dabble
// binary-to-BCD engine, frame-synchronous digit publish and a registered
// per-pixel glyph-cell lookup for a shared number renderer.
// Optional feature macro: LEADING_ZERO_BLANK_EN (leading-zero suppression on oBlank).

// One glyph cell: constant-bound X window compare plus its fixed X origin.
module score_digit_cell #(
  parameter int START_X    = 332,
  parameter int CHAR_WIDTH = 24,
  parameter int K          = 0
) (
  input  logic [9:0] iX,
  output logic       oHit,
  output logic [9:0] oX0
);
  localparam logic [10:0] LO = 11'(START_X + K * CHAR_WIDTH);
  localparam logic [10:0] HI = 11'(START_X + (K + 1) * CHAR_WIDTH - 1);

  assign oHit = ({1'b0, iX} >= LO) && ({1'b0, iX} <= HI);
  assign oX0  = LO[9:0];
endmodule

module score_digit_driver #(
  parameter int DIGITS      = 4,
  parameter int SCORE_W     = 14,
  parameter int START_X     = 332,
  parameter int START_Y     = 427,
  parameter int CHAR_WIDTH  = 24,
  parameter int CHAR_HEIGHT = 48
) (
  input  logic               iVGA_CLK,
  input  logic               iRST_n,
  input  logic               iAdd,
  input  logic [3:0]         iAddVal,
  input  logic               iClear,
  input  logic               iFrameStart,
  input  logic [9:0]         iVGA_X,
  input  logic [9:0]         iVGA_Y,
  output logic [3:0]         oNum,
  output logic [9:0]         oStartX,
  output logic [9:0]         oStartY,
  output logic               oBlank,
  output logic               oBusy,
  output logic [SCORE_W-1:0] oScore
);
  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam int               BCD_W     = 4 * DIGITS;
  localparam int               CW        = $clog2(SCORE_W + 1);
  localparam logic [SCORE_W:0] MAX_SCORE = (SCORE_W + 1)'(pow10(DIGITS) - 1);
  localparam logic [CW-1:0]    CNT_INIT  = CW'(SCORE_W);
  localparam logic [10:0]      Y_LO      = 11'(START_Y);
  localparam logic [10:0]      Y_HI      = 11'(START_Y + CHAR_HEIGHT - 1);
  localparam logic [9:0]       X0        = 10'(START_X);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // State; digit arrays are indexed by cell, cell 0 = most significant digit.
  logic [SCORE_W-1:0]          score_q, score_d;
  logic                        dirty_q, dirty_d;
  logic                        pend_q, pend_d;
  logic [1:0]                  state_q, state_d;
  logic [SCORE_W-1:0]          sh_q, sh_d;
  logic [BCD_W-1:0]            bcd_q, bcd_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [DIGITS-1:0][3:0]      shadow_q, shadow_d;
  logic [DIGITS-1:0][3:0]      disp_q, disp_d;
  logic [3:0]                  num_q, num_d;
  logic [9:0]                  sx_q, sx_d;
  logic                        blank_q, blank_d;

  logic [SCORE_W:0]            sum;
  logic                        score_chg;
  logic                        dirty_clr;
  logic                        pend_set;
  logic                        busy;
  logic                        publish;
  logic [BCD_W-1:0]            bcd_adj;
  logic                        row_hit;
  logic [DIGITS-1:0]           cell_hit;
  logic [DIGITS-1:0][9:0]      cell_x0;
  logic [DIGITS-1:0]           cell_blank;

  assign busy    = (state_q != S_IDLE);
  assign publish = iFrameStart & pend_q & ~busy;

  // Score update: clear beats add; the sum is one bit wider so the clamp sees overflow.
  always_comb begin
    sum     = {1'b0, score_q} + {{(SCORE_W - 3){1'b0}}, iAddVal};
    score_d = score_q;
    if (iClear)    score_d = '0;
    else if (iAdd) score_d = (sum > MAX_SCORE) ? MAX_SCORE[SCORE_W-1:0] : sum[SCORE_W-1:0];
    score_chg = (score_d != score_q);
  end

  // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < DIGITS; i++)
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? 4'(bcd_q[4*i +: 4] + 4'd3) : bcd_q[4*i +: 4];
  end

  // Conversion FSM: a started conversion always runs to DONE; new changes only re-arm dirty.
  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    dirty_clr = 1'b0;
    pend_set  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (dirty_q) begin
          dirty_clr = 1'b1;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        sh_d    = score_q;
        bcd_d   = '0;
        cnt_d   = CNT_INIT;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        bcd_d = {bcd_adj[BCD_W-2:0], sh_q[SCORE_W-1]};
        sh_d  = {sh_q[SCORE_W-2:0], 1'b0};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        for (int k = 0; k < DIGITS; k++) shadow_d[k] = bcd_q[4*(DIGITS-1-k) +: 4];
        pend_set = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Dirty/pending bookkeeping and frame-synchronous publish of the shadow digits.
  always_comb begin
    dirty_d = score_chg | (dirty_q & ~dirty_clr);
    pend_d  = pend_q;
    if (pend_set)     pend_d = 1'b1;
    else if (publish) pend_d = 1'b0;
    disp_d = publish ? shadow_q : disp_q;
  end

  // Per-cell X window compares, one instance per digit.
  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_cell
      score_digit_cell #(
        .START_X   (START_X),
        .CHAR_WIDTH(CHAR_WIDTH),
        .K         (g)
      ) u_cell (
        .iX  (iVGA_X),
        .oHit(cell_hit[g]),
        .oX0 (cell_x0[g])
      );
    end
  endgenerate

  assign row_hit = ({1'b0, iVGA_Y} >= Y_LO) && ({1'b0, iVGA_Y} <= Y_HI);

`ifdef LEADING_ZERO_BLANK_EN
  // Cell k is blank while every displayed digit up to and including k is zero; last digit always shows.
  always_comb begin
    logic lz_run;
    lz_run     = 1'b1;
    cell_blank = '0;
    for (int k = 0; k < DIGITS; k++) begin
      lz_run        = lz_run & (disp_q[k] == 4'd0);
      cell_blank[k] = lz_run & (k != DIGITS - 1);
    end
  end
`else
  assign cell_blank = '0;
`endif

  // Pixel lookup: cells are disjoint, so at most one hit selects the outputs.
  always_comb begin
    num_d   = 4'd0;
    sx_d    = X0;
    blank_d = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (row_hit && cell_hit[k]) begin
        num_d   = disp_q[k];
        sx_d    = cell_x0[k];
        blank_d = cell_blank[k];
      end
    end
  end

  // All state registers; synchronous active-low reset discards any conversion in flight.
  always_ff @(posedge iVGA_CLK) begin
    if (!iRST_n) begin
      score_q  <= '0;
      dirty_q  <= 1'b0;
      pend_q   <= 1'b0;
      state_q  <= S_IDLE;
      sh_q     <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      disp_q   <= '0;
      num_q    <= 4'd0;
      sx_q     <= X0;
      blank_q  <= 1'b0;
    end else begin
      score_q  <= score_d;
      dirty_q  <= dirty_d;
      pend_q   <= pend_d;
      state_q  <= state_d;
      sh_q     <= sh_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      disp_q   <= disp_d;
      num_q    <= num_d;
      sx_q     <= sx_d;
      blank_q  <= blank_d;
    end
  end

  assign oNum    = num_q;
  assign oStartX = sx_q;
  assign oStartY = 10'(START_Y);
  assign oBlank  = blank_q;
  assign oBusy   = busy;
  assign oScore  = score_q;
endmodule

// File: doc/score_digit_driver.md
# score_digit_driver

Drives the digit inputs of a shared on-screen number renderer. It holds the game score as a saturating binary counter and converts it to BCD with a sequential shift-add-3 (double-dabble) engine. Converted digits are published only at frame start, so a frame never shows a half-updated score. For each pixel it outputs the digit value and glyph start coordinates that the renderer needs.

## Interface
Parameters:
- DIGITS, 4, number of decimal digits shown; the most significant digit is leftmost.
- SCORE_W, 14, binary score width; must satisfy 2^SCORE_W > 10^DIGITS − 1.
- START_X, 332, screen X of the leftmost digit.
- START_Y, 427, screen Y of the digit row.
- CHAR_WIDTH, 24, glyph width in pixels.
- CHAR_HEIGHT, 48, glyph height in pixels.

Ports:
- iVGA_CLK  in  1  pixel clock; all logic runs on its rising edge.
- iRST_n  in  1  reset: synchronous, active-low, on iVGA_CLK.
- iAdd  in  1  single-cycle pulse; adds iAddVal to the score.
- iAddVal  in  4  increment amount, 0–15.
- iClear  in  1  single-cycle pulse; sets the score to 0.
- iFrameStart  in  1  single-cycle pulse at the start of vertical blank.
- iVGA_X  in  10  current pixel X.
- iVGA_Y  in  10  current pixel Y.
- oNum  out  4  BCD digit for the current pixel's glyph cell.
- oStartX  out  10  X origin of that cell.
- oStartY  out  10  Y origin of the digit row (always START_Y).
- oBlank  out  1  cell is a suppressed leading zero (see Configuration).
- oBusy  out  1  conversion engine is active.
- oScore  out  SCORE_W  current binary score.

## Operation
- Score register:
  - iClear sets the score to 0.
  - Otherwise, iAdd sets score ← min(score + iAddVal, 10^DIGITS − 1). Compute the sum at SCORE_W+1 bits before the compare.
  - Any change to the score sets the `dirty` flag.
  - If iClear and iAdd arrive in the same cycle, iClear wins.
- Conversion FSM, states IDLE, LOAD, SHIFT, DONE:
  - IDLE: if dirty, clear dirty and go to LOAD.
  - LOAD: capture oScore into the shift register, zero the BCD accumulator, set the bit counter to SCORE_W, go to SHIFT.
  - SHIFT: each cycle, add 3 to every BCD nibble ≥ 5, then shift left by one bit with the binary MSB entering. Decrement the counter; go to DONE when it reaches 0.
  - DONE: copy the BCD accumulator to the shadow digits, set `pending`, go to IDLE.
  - oBusy = 1 in LOAD, SHIFT and DONE.
  - A score change during conversion sets dirty; the engine reconverts after DONE. A running conversion is never aborted.
- Publish:
  - On iFrameStart with pending = 1 and oBusy = 0, copy the shadow digits to the display digits and clear pending.
  - On iFrameStart while oBusy = 1, do nothing; publish at a later frame start.
- Pixel lookup (registered):
  - If the pixel lies inside the digit row (Y in [START_Y, START_Y+CHAR_HEIGHT−1]) and inside cell k (X in [START_X+k·CHAR_WIDTH, START_X+(k+1)·CHAR_WIDTH−1], k = 0..DIGITS−1): oNum = display digit k, with k=0 the most significant; oStartX = START_X + k·CHAR_WIDTH.
  - Otherwise: oNum = 0, oStartX = START_X, oBlank = 0.
  - Cell membership uses parallel constant-bound compares; no divider.

## Timing
- Reset values:
  - oNum = 0, oStartX = START_X, oStartY = START_Y, oBlank = 0, oBusy = 0, oScore = 0.
  - Score, shadow digits, display digits, dirty and pending all 0; FSM in IDLE.
- Reset asserted mid-conversion: FSM returns to IDLE and all partial results are discarded.
- Score update: oScore changes on the edge that samples iAdd/iClear (1-cycle latency).
- Conversion latency: SCORE_W + 2 cycles from LOAD entry to pending = 1 (16 cycles at defaults). Dirty is sampled in IDLE one cycle after the score changes.
- Publish latency: display digits change on the edge that samples a qualifying iFrameStart.
- Lookup latency: oNum, oStartX and oBlank reflect the iVGA_X/iVGA_Y values sampled one cycle earlier.

## Configuration
- LEADING_ZERO_BLANK_EN defined: oBlank = 1 for cell k when display digits 0..k are all zero and k < DIGITS−1. The least significant digit is never blanked. The renderer draws nothing for blanked cells.
- LEADING_ZERO_BLANK_EN undefined: oBlank is tied to 0 and all digits show, leading zeros included.

## Test plan
- Reset, then score 0 → pixel (333, 430) gives oNum=0, oStartX=332; pixel (0, 0) gives oNum=0, oStartX=332, oBlank=0.
- iAdd with iAddVal=7 → oScore=7 next cycle; oBusy for 16 cycles; after iFrameStart, pixel (404, 430) (cell 3) gives oNum=7, oStartX=404.
- Add 15 repeatedly from 9990 → oScore saturates at 9999; after publish, all four cells read 9.
- iAdd and iClear in the same cycle with score 50 → oScore=0.
- iAdd during SHIFT, then iFrameStart while busy → no publish that frame; the next iFrameStart after reconversion publishes the final value.
- With LEADING_ZERO_BLANK_EN and score 42 → cells 0 and 1 have oBlank=1, cells 2 and 3 have oBlank=0; with score 0, only cell 3 is unblanked.
